// File: rtl/product_accumulator_pkg.sv
// Shared definitions for the product accumulator: state encodings, default widths
// and a constant-evaluable ceiling-log2 helper.
package product_accumulator_pkg;

    localparam logic [1:0] IDLE_ENC  = 2'b00;
    localparam logic [1:0] ACCUM_ENC = 2'b01;
    localparam logic [1:0] HOLD_ENC  = 2'b10;

    localparam int PROD_W_DEF = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE_ENC,
        ST_ACCUM = ACCUM_ENC,
        ST_HOLD  = HOLD_ENC
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// Unsigned saturating adder: the carry-out of a+b clamps the result to all-ones
// and raises sat for that addition.
module sat_adder #(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             sat
);

    logic [ACC_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b};
        sat = raw[ACC_W];
        sum = raw[ACC_W] ? {ACC_W{1'b1}} : raw[ACC_W-1:0];
    end

endmodule

// File: rtl/product_accumulator.sv
// Sums LEN accepted multiplier products into a saturating result, then holds it
// with valid/ready until the consumer takes it, backpressuring the producer meanwhile.
//
//   state | meaning
//   IDLE  | empty accumulator, waiting for the first product of a result
//   ACCUM | partial sum held, collecting products until LEN are taken
//   HOLD  | finished result on sum_o, producer stalled until sum_ready_i
module product_accumulator
    import product_accumulator_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int LEN    = 4,
    parameter int ACC_W  = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clear_i,
    input  logic [PROD_W-1:0]         prod_i,
    input  logic                      prod_valid_i,
    output logic                      prod_ready_o,
    output logic [ACC_W-1:0]          sum_o,
    output logic                      sum_valid_o,
    input  logic                      sum_ready_i,
    output logic                      ovf_o,
    output logic [clog2(LEN+1)-1:0]   count_o
);

    localparam int CNT_W = clog2(LEN + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

    state_t           state, state_nx;
    logic [ACC_W-1:0] acc, acc_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic             ovf, ovf_nx;

    logic             accept;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_sat;

    assign prod_ready_o = (state != ST_HOLD);
    assign accept       = prod_valid_i & prod_ready_o;
    assign prod_ext     = ACC_W'(prod_i);

    sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
        .a   (acc),
        .b   (prod_ext),
        .sum (add_sum),
        .sat (add_sat)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            acc   <= acc_nx;
            count <= count_nx;
            ovf   <= ovf_nx;
        end
    end

    always_comb begin
        state_nx = state;
        acc_nx   = acc;
        count_nx = count;
        ovf_nx   = ovf;
        // clear wins over everything, including a HOLD handshake and a presented product
        if (clear_i) begin
            state_nx = ST_IDLE;
            acc_nx   = '0;
            count_nx = '0;
            ovf_nx   = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        acc_nx   = prod_ext;
                        count_nx = CNT_W'(1);
                        ovf_nx   = 1'b0;
                        state_nx = (LEN == 1) ? ST_HOLD : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_nx   = add_sum;
                        ovf_nx   = ovf | add_sat;
                        count_nx = count + CNT_W'(1);
                        if (count == LAST_CNT) begin
                            state_nx = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (sum_ready_i) begin
                        state_nx = ST_IDLE;
                        acc_nx   = '0;
                        count_nx = '0;
                        ovf_nx   = 1'b0;
                    end
                end
                default: begin
                    state_nx = ST_IDLE;
                    acc_nx   = '0;
                    count_nx = '0;
                    ovf_nx   = 1'b0;
                end
            endcase
        end
    end

    assign sum_o       = acc;
    assign sum_valid_o = (state == ST_HOLD);
    assign ovf_o       = ovf;
    assign count_o     = count;

endmodule
